ex_div: RTL

- Iterative 32-bit divider (DIV/DIVU) in the execute stage, directly downstream of the ID/EX pipeline register.
- Takes the operand pair and signedness that the execute stage derives from ex_reg1, ex_reg2 and ex_aluop.
- Returns {remainder, quotient} for HI/LO after a fixed multi-cycle latency.
- The execute stage holds its stall request high while start_i=1 and ready_o=0, which freezes the pipeline stages upstream.

---
 rtl/ex_div.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/ex_div.sv
// ============================================================================
// ex_div : iterative radix-2 restoring divider (DIV/DIVU) for the execute stage
// Optional macro EX_DIV_ZERO_FLAG_EN adds the dbz_o divide-by-zero flag.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ex_div #(
   parameter int DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  signed_div_i,
   input  logic [DATA_W-1:0]     opdata1_i,
   input  logic [DATA_W-1:0]     opdata2_i,
   input  logic                  start_i,
   input  logic                  annul_i,
   output logic [2*DATA_W-1:0]   result_o,
`ifdef EX_DIV_ZERO_FLAG_EN
   output logic                  dbz_o,
`endif
   output logic                  ready_o
);

   localparam int CNT_W = $clog2(DATA_W) + 1;
   localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DATA_W);

   typedef enum logic [1:0] {
      S_FREE   = 2'd0,
      S_BYZERO = 2'd1,
      S_ON     = 2'd2,
      S_END    = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [2*DATA_W:0]     work_q, work_d;
   logic [DATA_W-1:0]     divisor_q, divisor_d;
   logic                  q_neg_q, q_neg_d;
   logic                  r_neg_q, r_neg_d;
   logic [2*DATA_W-1:0]   result_q, result_d;
   logic                  ready_q, ready_d;
`ifdef EX_DIV_ZERO_FLAG_EN
   logic                  dbz_q, dbz_d;
`endif

   logic                  op1_neg, op2_neg;
   logic [DATA_W-1:0]     op1_abs, op2_abs;
   logic [DATA_W:0]       diff;
   logic [DATA_W-1:0]     quot_raw, rem_raw, quot_fix, rem_fix;

   always_comb begin
      op1_neg  = signed_div_i & opdata1_i[DATA_W-1];
      op2_neg  = signed_div_i & opdata2_i[DATA_W-1];
      op1_abs  = op1_neg ? (~opdata1_i + 1'b1) : opdata1_i;
      op2_abs  = op2_neg ? (~opdata2_i + 1'b1) : opdata2_i;
      diff     = {1'b0, work_q[2*DATA_W-1:DATA_W]} - {1'b0, divisor_q};
      quot_raw = work_q[DATA_W-1:0];
      rem_raw  = work_q[2*DATA_W:DATA_W+1];
      quot_fix = q_neg_q ? (~quot_raw + 1'b1) : quot_raw;
      rem_fix  = r_neg_q ? (~rem_raw + 1'b1) : rem_raw;
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      work_d    = work_q;
      divisor_d = divisor_q;
      q_neg_d   = q_neg_q;
      r_neg_d   = r_neg_q;
      result_d  = result_q;
      ready_d   = ready_q;
`ifdef EX_DIV_ZERO_FLAG_EN
      dbz_d     = dbz_q;
`endif
      case (state_q)
         S_FREE: begin
            if (start_i && !annul_i) begin
               if (opdata2_i == '0) begin
                  state_d = S_BYZERO;
               end else begin
                  state_d   = S_ON;
                  cnt_d     = '0;
                  // Dividend sits one place up so the first step already sees its MSB.
                  work_d    = {{DATA_W{1'b0}}, op1_abs, 1'b0};
                  divisor_d = op2_abs;
                  q_neg_d   = op1_neg ^ op2_neg;
                  r_neg_d   = op1_neg;
               end
            end
         end
         S_BYZERO: begin
            if (annul_i) begin
               state_d = S_FREE;
            end else begin
               state_d  = S_END;
               result_d = '0;
               ready_d  = 1'b1;
`ifdef EX_DIV_ZERO_FLAG_EN
               dbz_d    = 1'b1;
`endif
            end
         end
         S_ON: begin
            if (annul_i) begin
               state_d = S_FREE;
               ready_d = 1'b0;
            end else if (cnt_q != C_CNT_LAST) begin
               if (diff[DATA_W]) begin
                  work_d = {work_q[2*DATA_W-1:0], 1'b0};
               end else begin
                  work_d = {diff[DATA_W-1:0], work_q[DATA_W-1:0], 1'b1};
               end
               cnt_d = cnt_q + 1'b1;
            end else begin
               result_d = {rem_fix, quot_fix};
               ready_d  = 1'b1;
               state_d  = S_END;
            end
         end
         S_END: begin
            if (!start_i) begin
               state_d  = S_FREE;
               ready_d  = 1'b0;
               result_d = '0;
`ifdef EX_DIV_ZERO_FLAG_EN
               dbz_d    = 1'b0;
`endif
            end
         end
         default: state_d = S_FREE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_FREE;
         cnt_q     <= '0;
         work_q    <= '0;
         divisor_q <= '0;
         q_neg_q   <= 1'b0;
         r_neg_q   <= 1'b0;
         result_q  <= '0;
         ready_q   <= 1'b0;
`ifdef EX_DIV_ZERO_FLAG_EN
         dbz_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         work_q    <= work_d;
         divisor_q <= divisor_d;
         q_neg_q   <= q_neg_d;
         r_neg_q   <= r_neg_d;
         result_q  <= result_d;
         ready_q   <= ready_d;
`ifdef EX_DIV_ZERO_FLAG_EN
         dbz_q     <= dbz_d;
`endif
      end
   end

   assign result_o = result_q;
   assign ready_o  = ready_q;
`ifdef EX_DIV_ZERO_FLAG_EN
   assign dbz_o    = dbz_q;
`endif

endmodule

`default_nettype wire
